idle_power_ctrl: RTL



---
 rtl/idle_power_pkg.sv | 17 +
 rtl/idle_power_ctrl_if.sv | 30 +++
 rtl/idle_power_fsm.sv | 108 ++++++++++
 rtl/idle_power_ctrl.sv | 47 ++++
 4 files changed

// File: rtl/idle_power_pkg.sv
// Shared types for the per-peripheral idle power controller.
package idle_power_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      GATED    = 3'd1,
      PDN_WAIT = 3'd2,
      OFF      = 3'd3,
      PUP_WAIT = 3'd4
   } pstate_e;

   // Counter must be able to hold ACK_TIMEOUT itself so it can saturate there.
   function automatic int tmo_cnt_w(input int ack_timeout);
      return $clog2(ack_timeout + 1);
   endfunction

endpackage

// File: rtl/idle_power_ctrl_if.sv
// Idle-counter inputs, power-switch handshake and per-peripheral power outputs.
interface idle_power_ctrl_if #(
   parameter int N = 4,
   parameter int W = 16
);
   logic [N-1:0][W-1:0] idle_count;
   logic [N-1:0]        recent_activity;
   logic [N-1:0]        periph_en;
   logic [N-1:0]        wake_req;
   logic [W-1:0]        gate_thresh;
   logic [W-1:0]        pdn_thresh;
   logic [N-1:0]        pwr_good;
   logic [N-1:0]        err_clr;
   logic [N-1:0]        clk_en;
   logic [N-1:0]        pwr_on;
   logic [N-1:0][2:0]   pstate;
   logic [N-1:0]        err;

   modport master (
      output idle_count, recent_activity, periph_en, wake_req,
             gate_thresh, pdn_thresh, pwr_good, err_clr,
      input  clk_en, pwr_on, pstate, err
   );

   modport slave (
      input  idle_count, recent_activity, periph_en, wake_req,
             gate_thresh, pdn_thresh, pwr_good, err_clr,
      output clk_en, pwr_on, pstate, err
   );
endinterface

// File: rtl/idle_power_fsm.sv
// Power-state FSM for one peripheral: clock gating, power-down handshake,
// wake latching and acknowledge-timeout detection.
module idle_power_fsm
   import idle_power_pkg::*;
#(
   parameter int W           = 16,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] idle_count,
   input  logic [W-1:0] gate_thresh,
   input  logic [W-1:0] pdn_thresh,
   input  logic         recent_activity,
   input  logic         periph_en,
   input  logic         wake_req,
   input  logic         pwr_good,
   input  logic         err_clr,
   output logic         clk_en,
   output logic         pwr_on,
   output logic         err,
   output pstate_e      pstate
);
   localparam int            CW       = tmo_cnt_w(ACK_TIMEOUT);
   localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] TMO_MAX  = CW'(ACK_TIMEOUT);

   pstate_e       state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wake_pend_q, wake_pend_d;
   logic          err_d, clk_en_d, pwr_on_d;
   logic          wake, tmo_hit, in_wait, enter_wait;

   always_comb begin
      state_d     = state_q;
      err_d       = err & ~err_clr;
      cnt_d       = cnt_q;
      wake_pend_d = wake_pend_q;
      wake        = wake_req | wake_pend_q | ~periph_en;
      tmo_hit     = (cnt_q == TMO_LAST);

      case (state_q)
         RUN:
            if (periph_en && !recent_activity && gate_thresh != '0 &&
                idle_count >= gate_thresh && !wake_req)
               state_d = GATED;
         GATED:
            if (wake)
               state_d = RUN;
            else if (pdn_thresh != '0 && idle_count >= pdn_thresh)
               state_d = PDN_WAIT;
         // A wake here is only latched; the rail must finish dropping first.
         PDN_WAIT:
            if (!pwr_good)
               state_d = OFF;
            else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = PUP_WAIT;
            end
         OFF:
            if (wake) state_d = PUP_WAIT;
         PUP_WAIT:
            if (pwr_good)
               state_d = RUN;
            else if (tmo_hit)
               err_d = 1'b1;
         default: state_d = RUN;
      endcase

      in_wait    = (state_q == PDN_WAIT) || (state_q == PUP_WAIT);
      enter_wait = (state_d != state_q) &&
                   ((state_d == PDN_WAIT) || (state_d == PUP_WAIT));
      if (enter_wait)
         cnt_d = '0;
      else if (in_wait && cnt_q != TMO_MAX)
         cnt_d = cnt_q + 1'b1;

      if (state_d == RUN)
         wake_pend_d = 1'b0;
      else if (state_q != RUN && wake_req)
         wake_pend_d = 1'b1;

      // Outputs decoded from the next state so they flop alongside pstate.
      clk_en_d = (state_d == RUN);
      pwr_on_d = (state_d == RUN) || (state_d == GATED) || (state_d == PUP_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         wake_pend_q <= 1'b0;
         err         <= 1'b0;
         clk_en      <= 1'b1;
         pwr_on      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wake_pend_q <= wake_pend_d;
         err         <= err_d;
         clk_en      <= clk_en_d;
         pwr_on      <= pwr_on_d;
      end
   end

   assign pstate = state_q;

endmodule

// File: rtl/idle_power_ctrl.sv
// Array of independent per-peripheral power FSMs sharing the global thresholds.
module idle_power_ctrl
   import idle_power_pkg::*;
#(
   parameter int N           = 4,
   parameter int W           = 16,
   parameter int ACK_TIMEOUT = 64
) (
   input logic              clk,
   input logic              rst,
   idle_power_ctrl_if.slave bus
);
   logic [N-1:0]      clk_en_w, pwr_on_w, err_w;
   logic [N-1:0][2:0] pstate_w;

   for (genvar i = 0; i < N; i++) begin : g_periph
      pstate_e st;

      idle_power_fsm #(
         .W           (W),
         .ACK_TIMEOUT (ACK_TIMEOUT)
      ) u_fsm (
         .clk             (clk),
         .rst             (rst),
         .idle_count      (bus.idle_count[i]),
         .gate_thresh     (bus.gate_thresh),
         .pdn_thresh      (bus.pdn_thresh),
         .recent_activity (bus.recent_activity[i]),
         .periph_en       (bus.periph_en[i]),
         .wake_req        (bus.wake_req[i]),
         .pwr_good        (bus.pwr_good[i]),
         .err_clr         (bus.err_clr[i]),
         .clk_en          (clk_en_w[i]),
         .pwr_on          (pwr_on_w[i]),
         .err             (err_w[i]),
         .pstate          (st)
      );

      assign pstate_w[i] = st;
   end

   assign bus.clk_en = clk_en_w;
   assign bus.pwr_on = pwr_on_w;
   assign bus.err    = err_w;
   assign bus.pstate = pstate_w;

endmodule
